// File: rtl/lfsr16_checker.sv
// lfsr16_checker
//
// Receive-side pattern checker for the 16-bit Fibonacci LFSR generator
// (taps 16,15,13,4; newest bit enters r[1]). The checker loads 16 received
// bits into its local register, then verifies that the following bits match
// the register's own prediction. Once enough consecutive matches have been
// seen it locks, free-runs the local copy, and counts mismatching bits.
// Too many errors inside one observation window drop it back to seeding.
//
// Optional feature: define LFSR16_CHK_BITCNT_EN to add the bit_cnt port,
// a saturating count of valid bits received while locked.
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   rst_n      asynchronous active-low reset
//   restart    synchronous resynchronise request (wins over bit_valid)
//   bit_in     received serial bit
//   bit_valid  qualifies bit_in; cycles with 0 change no state
//   locked     1 while in LOCKED
//   err_pulse  one-cycle pulse per mismatching bit while locked
//   err_cnt    saturating total of errors seen while locked
//   expected   local LFSR register r[16:1]
//   bit_cnt    (LFSR16_CHK_BITCNT_EN only) valid bits received while locked
//
// State table:
//   state      | meaning
//   ST_SEED    | loading 16 received bits into the local register
//   ST_VERIFY  | received bits shifted in, counting consecutive predictions
//   ST_LOCKED  | local register free-runs on its prediction, errors counted

module lfsr16_checker #(
    parameter int SYNC_LEN  = 16,
    parameter int WINDOW    = 64,
    parameter int LOSS_ERRS = 8,
    parameter int ERR_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             restart,
    input  logic             bit_in,
    input  logic             bit_valid,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_cnt,
    output logic [15:0]      expected
`ifdef LFSR16_CHK_BITCNT_EN
    ,
    output logic [31:0]      bit_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_SEED   = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    localparam logic [7:0]  SYNC_V   = 8'(SYNC_LEN);
    localparam logic [15:0] WIN_LAST = 16'(WINDOW - 1);
    localparam logic [15:0] LOSS_V   = 16'(LOSS_ERRS);

    state_t      state;
    state_t      state_nxt;

    logic [16:1] r;
    logic [4:0]  load_cnt;
    logic [7:0]  match_cnt;
    logic [15:0] win_cnt;
    logic [15:0] win_err;

    logic        pred;
    logic        mismatch;
    logic        load_done;
    logic        match_hit;
    logic [7:0]  match_nxt;
    logic        lock_hit;
    logic [15:0] win_err_nxt;
    logic        loss_hit;
    logic        win_end;

    assign pred      = r[16] ^ r[15] ^ r[13] ^ r[4];
    assign mismatch  = bit_in ^ pred;
    assign load_done = (load_cnt == 5'd15);

    // An all-zero register predicts zero forever, so it must never count
    // toward lock even though a zero stream "matches" it.
    assign match_hit = (bit_in == pred) && (r != 16'd0);
    assign match_nxt = match_hit ? (match_cnt + 8'd1) : 8'd0;
    assign lock_hit  = (match_nxt == SYNC_V);

    // The error on the last bit of a window still counts toward that window.
    assign win_err_nxt = win_err + {15'd0, mismatch};
    assign loss_hit    = (win_err_nxt >= LOSS_V);
    assign win_end     = (win_cnt == WIN_LAST);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_SEED;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        if (restart) begin
            state_nxt = ST_SEED;
        end else if (bit_valid) begin
            case (state)
                ST_SEED:   if (load_done) state_nxt = ST_VERIFY;
                ST_VERIFY: if (lock_hit)  state_nxt = ST_LOCKED;
                ST_LOCKED: if (loss_hit)  state_nxt = ST_SEED;
                default:                  state_nxt = ST_SEED;
            endcase
        end
    end

    // Outputs decoded from state and register
    always_comb begin
        locked   = (state == ST_LOCKED);
        expected = r;
    end

    // Datapath: shift register, counters and error reporting
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r         <= '0;
            load_cnt  <= '0;
            match_cnt <= '0;
            win_cnt   <= '0;
            win_err   <= '0;
            err_cnt   <= '0;
            err_pulse <= 1'b0;
        end else begin
            err_pulse <= 1'b0;
            if (restart) begin
                r         <= '0;
                load_cnt  <= '0;
                match_cnt <= '0;
                win_cnt   <= '0;
                win_err   <= '0;
                err_cnt   <= '0;
            end else if (bit_valid) begin
                case (state)
                    ST_SEED: begin
                        r         <= {r[15:1], bit_in};
                        load_cnt  <= load_done ? 5'd0 : (load_cnt + 5'd1);
                        match_cnt <= '0;
                    end
                    ST_VERIFY: begin
                        r         <= {r[15:1], bit_in};
                        match_cnt <= match_nxt;
                        if (lock_hit) begin
                            win_cnt <= '0;
                            win_err <= '0;
                        end
                    end
                    ST_LOCKED: begin
                        // Shift the prediction so line errors never corrupt
                        // the local copy of the sequence.
                        r <= {r[15:1], pred};
                        if (mismatch) begin
                            err_pulse <= 1'b1;
                            if (err_cnt != {ERR_W{1'b1}}) begin
                                err_cnt <= err_cnt + 1'b1;
                            end
                        end
                        if (loss_hit) begin
                            load_cnt <= '0;
                            win_cnt  <= '0;
                            win_err  <= '0;
                        end else if (win_end) begin
                            win_cnt <= '0;
                            win_err <= '0;
                        end else begin
                            win_cnt <= win_cnt + 16'd1;
                            win_err <= win_err_nxt;
                        end
                    end
                    default: begin
                        r <= r;
                    end
                endcase
            end
        end
    end

`ifdef LFSR16_CHK_BITCNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt <= '0;
        end else if (restart) begin
            bit_cnt <= '0;
        end else if (bit_valid && (state == ST_LOCKED) && (bit_cnt != 32'hFFFF_FFFF)) begin
            bit_cnt <= bit_cnt + 32'd1;
        end
    end
`endif

endmodule
